// File: rtl/axis_frame_arbiter.sv
// Round-robin AXI-Stream frame arbiter: one input port owns the registered
// output from its first accepted beat until its tlast beat is accepted.
module axis_frame_arbiter #(
  parameter int PORTS      = 4,
  parameter int DATA_WIDTH = 64,
  parameter int KEEP_WIDTH = DATA_WIDTH / 8
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [PORTS*DATA_WIDTH-1:0]   input_axis_tdata,
  input  logic [PORTS*KEEP_WIDTH-1:0]   input_axis_tkeep,
  input  logic [PORTS-1:0]              input_axis_tvalid,
  input  logic [PORTS-1:0]              input_axis_tlast,
  input  logic [PORTS-1:0]              input_axis_tuser,
  output logic [PORTS-1:0]              input_axis_tready,
  output logic [DATA_WIDTH-1:0]         output_axis_tdata,
  output logic [KEEP_WIDTH-1:0]         output_axis_tkeep,
  output logic                          output_axis_tvalid,
  output logic                          output_axis_tlast,
  output logic                          output_axis_tuser,
  input  logic                          output_axis_tready,
  output logic                          grant_valid,
  output logic [$clog2(PORTS)-1:0]      grant_port
);

  localparam int PW = $clog2(PORTS);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] FRAME = 1'b1;

  logic [0:0]            state;
  logic [PW-1:0]         last_port;
  logic [PW-1:0]         sel_port;
  logic                  req_any;
  logic                  out_free;
  logic                  accept;
  logic                  cur_valid;
  logic                  cur_last;
  logic                  cur_user;
  logic [DATA_WIDTH-1:0] cur_data;
  logic [KEEP_WIDTH-1:0] cur_keep;

  function automatic logic [PW-1:0] port_at(input logic [PW-1:0] base,
                                            input int unsigned   off);
    int unsigned v;
    v = (32'(base) + off) % unsigned'(PORTS);
    return PW'(v);
  endfunction

  // First requester strictly after last_port, wrapping; last_port itself is checked last.
  always_comb begin
    sel_port = '0;
    req_any  = 1'b0;
    for (int unsigned k = 1; k <= unsigned'(PORTS); k++) begin
      if (!req_any && input_axis_tvalid[port_at(last_port, k)]) begin
        req_any  = 1'b1;
        sel_port = port_at(last_port, k);
      end
    end
  end

  always_comb begin
    cur_valid = input_axis_tvalid[grant_port];
    cur_last  = input_axis_tlast[grant_port];
    cur_user  = input_axis_tuser[grant_port];
    cur_data  = input_axis_tdata[int'(grant_port)*DATA_WIDTH +: DATA_WIDTH];
    cur_keep  = input_axis_tkeep[int'(grant_port)*KEEP_WIDTH +: KEEP_WIDTH];
  end

  assign out_free = !output_axis_tvalid || output_axis_tready;
  assign accept   = (state == FRAME) && cur_valid && out_free;

  always_comb begin
    input_axis_tready = '0;
    if (state == FRAME && out_free) begin
      input_axis_tready[grant_port] = 1'b1;
    end
  end

  // Frame end drops to IDLE, so the next grant is always at least one cycle later.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      grant_valid <= 1'b0;
      grant_port  <= '0;
      last_port   <= PW'(PORTS - 1);
    end else if (state == IDLE) begin
      if (req_any) begin
        state       <= FRAME;
        grant_valid <= 1'b1;
        grant_port  <= sel_port;
      end
    end else begin
      if (accept && cur_last) begin
        state       <= IDLE;
        grant_valid <= 1'b0;
        last_port   <= grant_port;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      output_axis_tvalid <= 1'b0;
      output_axis_tlast  <= 1'b0;
      output_axis_tuser  <= 1'b0;
      output_axis_tdata  <= '0;
      output_axis_tkeep  <= '0;
    end else if (accept) begin
      output_axis_tvalid <= 1'b1;
      output_axis_tlast  <= cur_last;
      output_axis_tuser  <= cur_user;
      output_axis_tdata  <= cur_data;
      output_axis_tkeep  <= cur_keep;
    end else if (output_axis_tready) begin
      output_axis_tvalid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_axis_frame_arbiter.sv
// Scoreboard bench for axis_frame_arbiter: frames are staged per port, a
// frame-level round-robin model builds the expected output beat order.
module tb_axis_frame_arbiter;

  localparam int P  = 4;
  localparam int DW = 64;
  localparam int KW = 8;
  localparam int PW = 2;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  logic [P*DW-1:0] in_tdata;
  logic [P*KW-1:0] in_tkeep;
  logic [P-1:0]    in_tvalid, in_tlast, in_tuser, in_tready;
  logic [DW-1:0]   out_tdata;
  logic [KW-1:0]   out_tkeep;
  logic            out_tvalid, out_tlast, out_tuser, out_tready;
  logic            grant_valid;
  logic [PW-1:0]   grant_port;

  always #5 clk = ~clk;

  axis_frame_arbiter #(.PORTS(P), .DATA_WIDTH(DW), .KEEP_WIDTH(KW)) dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .input_axis_tdata   (in_tdata),
    .input_axis_tkeep   (in_tkeep),
    .input_axis_tvalid  (in_tvalid),
    .input_axis_tlast   (in_tlast),
    .input_axis_tuser   (in_tuser),
    .input_axis_tready  (in_tready),
    .output_axis_tdata  (out_tdata),
    .output_axis_tkeep  (out_tkeep),
    .output_axis_tvalid (out_tvalid),
    .output_axis_tlast  (out_tlast),
    .output_axis_tuser  (out_tuser),
    .output_axis_tready (out_tready),
    .grant_valid        (grant_valid),
    .grant_port         (grant_port)
  );

  typedef struct {
    logic [DW-1:0] d;
    logic [KW-1:0] k;
    logic          l;
    logic          u;
  } beat_t;

  beat_t pq[P][$];
  int    flen[P][$];
  beat_t exp_q[$];
  int    gcnt[P];
  int    model_last = P - 1;
  int    n_vec = 0;
  int    n_err = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic add_frame(input int p, input int len, input logic [KW-1:0] lk, input logic lu);
    for (int b = 0; b < len; b++) begin
      beat_t x;
      x.d = {8'(p), 8'(flen[p].size()), 16'(b), 32'($urandom)};
      x.k = (b == len - 1) ? lk : '1;
      x.l = (b == len - 1);
      x.u = (b == len - 1) ? lu : 1'b0;
      pq[p].push_back(x);
    end
    flen[p].push_back(len);
  endtask

  // Every staged port requests from the start and never gaps before a first
  // beat, so frames leave in plain round-robin order over ports with work left.
  task automatic schedule();
    int pos[P];
    int total = 0;
    for (int p = 0; p < P; p++) begin
      pos[p] = 0;
      total += flen[p].size();
    end
    while (total > 0) begin
      for (int k = 1; k <= P; k++) begin
        int c;
        c = (model_last + k) % P;
        if (flen[c].size() > 0) begin
          int n;
          n = flen[c].pop_front();
          for (int b = 0; b < n; b++) exp_q.push_back(pq[c][pos[c] + b]);
          pos[c] += n;
          model_last = c;
          total--;
          break;
        end
      end
    end
  endtask

  function automatic bit busy();
    for (int p = 0; p < P; p++) if (pq[p].size() > 0) return 1'b1;
    return exp_q.size() != 0;
  endfunction

  task automatic drive(input int mode, input int cyc);
    for (int p = 0; p < P; p++) begin
      if (pq[p].size() == 0) begin
        in_tvalid[p] = 1'b0;
        in_tlast[p]  = 1'b0;
        in_tuser[p]  = 1'b0;
        in_tdata[p*DW +: DW] = '0;
        in_tkeep[p*KW +: KW] = '0;
      end else begin
        beat_t h;
        h = pq[p][0];
        in_tdata[p*DW +: DW] = h.d;
        in_tkeep[p*KW +: KW] = h.k;
        in_tlast[p] = h.l;
        in_tuser[p] = h.u;
        if (gcnt[p] > 0) begin
          in_tvalid[p] = 1'b0;
          gcnt[p]--;
        end else begin
          in_tvalid[p] = 1'b1;
        end
      end
    end
    case (mode)
      0: out_tready = 1'b1;
      1: out_tready = ((cyc % 4) == 0) || ((cyc % 4) == 3);
      default: out_tready = ($urandom_range(0, 9) < 7);
    endcase
  endtask

  task automatic sample(input int gmode);
    for (int p = 0; p < P; p++) begin
      if (in_tvalid[p] && in_tready[p]) begin
        logic lst;
        lst = pq[p][0].l;
        void'(pq[p].pop_front());
        if (lst)             gcnt[p] = 0;
        else if (gmode == 1) gcnt[p] = int'($urandom_range(0, 2));
        else if (gmode == 2) gcnt[p] = 3;
        else                 gcnt[p] = 0;
      end
    end
  endtask

  task automatic clear_bench();
    for (int p = 0; p < P; p++) begin
      pq[p].delete();
      flen[p].delete();
      gcnt[p] = 0;
    end
    exp_q.delete();
    model_last = P - 1;
    in_tvalid = '0;
  endtask

  task automatic run(input int mode, input int gmode, input int exp_first);
    int cyc = 0;
    while (busy() && cyc < 3000) begin
      drive(mode, cyc);
      @(negedge clk);
      if (cyc == 0 && exp_first >= 0) chk("idle_tready", 128'(in_tready), 128'(0));
      sample(gmode);
      @(posedge clk); #1;
      if (cyc == 0 && exp_first >= 0) begin
        chk("first_grant_valid", 128'(grant_valid), 128'(1));
        chk("first_grant_port", 128'(grant_port), 128'(exp_first));
      end
      cyc++;
    end
    if (cyc >= 3000) begin
      n_vec++;
      n_err++;
      $display("FAIL run_timeout: got %0d pending beats expected 0", exp_q.size());
    end
    in_tvalid  = '0;
    out_tready = 1'b1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    clear_bench();
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  // Output-side monitor: scoreboard pops plus handshake rules checked every cycle.
  logic          prev_stall = 1'b0, acc_prev = 1'b0, lacc_prev = 1'b0;
  logic [DW-1:0] sv_d;
  logic [KW-1:0] sv_k;
  logic          sv_l, sv_u;
  logic [P-1:0]  own_mask;
  beat_t         e;

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_stall <= 1'b0;
      acc_prev   <= 1'b0;
      lacc_prev  <= 1'b0;
    end else begin
      if (prev_stall)
        chk("stall_hold", 128'({out_tvalid, out_tdata, out_tkeep, out_tlast, out_tuser}),
            128'({1'b1, sv_d, sv_k, sv_l, sv_u}));
      if (acc_prev)  chk("latency", 128'(out_tvalid), 128'(1));
      if (lacc_prev) chk("arb_gap", 128'(grant_valid), 128'(0));
      if (out_tvalid && !out_tready) chk("ready_stall", 128'(in_tready), 128'(0));
      own_mask = grant_valid ? (P'(1) << grant_port) : '0;
      chk("ready_owner", 128'(in_tready & ~own_mask), 128'(0));
      if (out_tvalid && out_tready) begin
        if (exp_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL extra_beat: got %h expected no beat", out_tdata);
        end else begin
          e = exp_q.pop_front();
          chk("beat", 128'({out_tdata, out_tkeep, out_tlast, out_tuser}),
              128'({e.d, e.k, e.l, e.u}));
        end
      end
      prev_stall <= out_tvalid && !out_tready;
      sv_d       <= out_tdata;
      sv_k       <= out_tkeep;
      sv_l       <= out_tlast;
      sv_u       <= out_tuser;
      acc_prev   <= |(in_tvalid & in_tready);
      lacc_prev  <= |(in_tvalid & in_tready & in_tlast);
    end
  end

  initial begin
    int cnt;
    int cyc;
    in_tdata   = '0;
    in_tkeep   = '0;
    in_tlast   = '0;
    in_tuser   = '0;
    in_tvalid  = '1;
    out_tready = 1'b1;
    for (int p = 0; p < P; p++) gcnt[p] = 0;

    #2;
    chk("rst_out_tvalid", 128'(out_tvalid), 128'(0));
    chk("rst_out_tdata", 128'(out_tdata), 128'(0));
    chk("rst_grant_valid", 128'(grant_valid), 128'(0));
    chk("rst_grant_port", 128'(grant_port), 128'(0));
    chk("rst_in_tready", 128'(in_tready), 128'(0));
    in_tvalid = '0;
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    // Single port, 5 beats, short last keep.
    add_frame(1, 5, 8'h1F, 1'b0);
    schedule();
    run(0, 0, 1);

    // Three simultaneous requesters right after reset.
    do_reset();
    add_frame(0, 2, '1, 1'b0);
    add_frame(2, 2, '1, 1'b0);
    add_frame(3, 2, '1, 1'b0);
    schedule();
    run(0, 0, 0);

    // Output back-pressure pattern 1,0,0,1.
    add_frame(0, 4, 8'h0F, 1'b0);
    schedule();
    run(1, 0, -1);

    // Port 1 frame moves the pointer; then owner 2 stalls mid-frame while 0 waits.
    add_frame(1, 1, 8'h01, 1'b0);
    schedule();
    run(0, 0, 1);
    add_frame(2, 4, '1, 1'b0);
    add_frame(0, 3, '1, 1'b1);
    schedule();
    run(0, 2, 2);

    // Back-to-back single-beat frames, second flagged with tuser.
    do_reset();
    add_frame(0, 1, 8'hFF, 1'b0);
    add_frame(1, 1, 8'h0F, 1'b1);
    schedule();
    run(0, 0, 0);

    for (int it = 0; it < 12; it++) begin
      for (int p = 0; p < P; p++) begin
        int nf;
        nf = int'($urandom_range(0, 3));
        for (int f = 0; f < nf; f++)
          add_frame(p, int'($urandom_range(1, 6)), KW'($urandom_range(1, 255)),
                    1'($urandom_range(0, 1)));
      end
      schedule();
      run(2, 1, -1);
    end

    // Reset asserted mid-frame, between clock edges.
    add_frame(2, 6, '1, 1'b0);
    schedule();
    cnt = 0;
    cyc = 0;
    while (cnt < 3 && cyc < 100) begin
      drive(0, cyc);
      @(negedge clk);
      if (in_tvalid[2] && in_tready[2]) cnt++;
      sample(0);
      @(posedge clk); #1;
      cyc++;
    end
    if (cyc >= 100) begin
      n_vec++;
      n_err++;
      $display("FAIL midframe_timeout: got %0d beats expected 3", cnt);
    end
    #2 rst_n = 1'b0;
    #1;
    chk("arst_out_tvalid", 128'(out_tvalid), 128'(0));
    chk("arst_out_tdata", 128'(out_tdata), 128'(0));
    chk("arst_out_tkeep", 128'(out_tkeep), 128'(0));
    chk("arst_out_tlast_tuser", 128'({out_tlast, out_tuser}), 128'(0));
    chk("arst_grant", 128'({grant_valid, grant_port}), 128'(0));
    chk("arst_in_tready", 128'(in_tready), 128'(0));
    clear_bench();
    @(posedge clk); #1;
    add_frame(0, 2, '1, 1'b0);
    add_frame(3, 2, '1, 1'b0);
    schedule();
    rst_n = 1'b1;
    run(0, 0, 0);

    repeat (3) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
